// File: rtl/wbdbgbus_pkg.sv
// Shared types and constants for the debug-bus response path.
// Build option: define WBDBGBUS_CHECKSUM_EN to append an XOR checksum byte
// to every response frame (6-byte frames instead of 5).
package wbdbgbus_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND
    } resp_state_t;

    localparam int RESP_WORD_WIDTH = 36;
    localparam int RESP_OP_WIDTH   = 4;

`ifdef WBDBGBUS_CHECKSUM_EN
    localparam int FRAME_BYTES = 6;
`else
    localparam int FRAME_BYTES = 5;
`endif

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    // Data byte k of a response word, MSB first; byte0 carries the opcode
    // zero-extended to a full byte.
    function automatic logic [7:0] frame_byte(input logic [RESP_WORD_WIDTH-1:0] word,
                                              input logic [2:0]                 idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {{(8-RESP_OP_WIDTH){1'b0}}, word[35:32]};
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wbdbgbus_resp_serializer.sv
// Response serializer: pops 36-bit response words from the response FIFO
// and sends each as a fixed-length byte frame, MSB first, to the UART TX.
// Build option: WBDBGBUS_CHECKSUM_EN adds a trailing XOR checksum byte.
module wbdbgbus_resp_serializer
    import wbdbgbus_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    output logic                       o_rd_en,
    input  logic [RESP_WORD_WIDTH-1:0] i_rd_data,
    input  logic                       i_rd_valid,
    input  logic                       i_empty,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_busy,
    output logic [CNT_WIDTH-1:0]       o_words_sent,
    output logic                       o_underflow
);

    resp_state_t                state;
    resp_state_t                state_nxt;
    logic [2:0]                 idx;
    logic [RESP_WORD_WIDTH-1:0] frame;
    logic [CNT_WIDTH-1:0]       words_sent;
    logic                       underflow;
    logic [7:0]                 byte_sel;
    logic                       tx_fire;
    logic                       last_fire;

    assign tx_fire   = (state == S_SEND) && i_tx_ready;
    assign last_fire = tx_fire && (idx == LAST_IDX);

    // Select the outgoing byte for the current index; the checksum byte is last
    always_comb begin
        byte_sel = frame_byte(frame, idx);
`ifdef WBDBGBUS_CHECKSUM_EN
        if (idx == LAST_IDX) begin
            byte_sel = frame_byte(frame, 3'd0) ^ frame_byte(frame, 3'd1) ^
                       frame_byte(frame, 3'd2) ^ frame_byte(frame, 3'd3) ^
                       frame_byte(frame, 3'd4);
        end
`endif
    end

    // Next-state and handshake outputs; pops are withheld while reset is held
    // so a word queued across a reset is not silently consumed
    always_comb begin
        state_nxt  = state;
        o_rd_en    = 1'b0;
        o_tx_valid = 1'b0;
        case (state)
            S_IDLE: begin
                o_rd_en = !i_empty && i_rst_n;
                if (o_rd_en) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = i_rd_valid ? S_SEND : S_IDLE;
            end
            S_SEND: begin
                o_tx_valid = 1'b1;
                if (last_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_tx_data    = (state == S_SEND) ? byte_sel : 8'h00;
    assign o_busy       = (state != S_IDLE);
    assign o_words_sent = words_sent;
    assign o_underflow  = underflow;

    // State register; reset aborts any frame in progress
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame capture, byte index, completed-frame counter and sticky underflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame      <= '0;
            idx        <= 3'd0;
            words_sent <= '0;
            underflow  <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                if (i_rd_valid) begin
                    frame <= i_rd_data;
                    idx   <= 3'd0;
                end else begin
                    underflow <= 1'b1;
                end
            end
            if (tx_fire) begin
                idx <= idx + 3'd1;
            end
            if (last_fire) begin
                words_sent <= words_sent + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_wbdbgbus_resp_serializer.sv
// Testbench for wbdbgbus_resp_serializer: FIFO responder, UART ready driver,
// byte monitor and a frame-level reference model.
module tb_wbdbgbus_resp_serializer;

    localparam int CNT_W = 2;
`ifdef WBDBGBUS_CHECKSUM_EN
    localparam int FB = 6;
`else
    localparam int FB = 5;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              o_rd_en;
    logic [35:0]       i_rd_data = '0;
    logic              i_rd_valid = 1'b0;
    logic              i_empty;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready = 1'b1;
    logic              o_busy;
    logic [CNT_W-1:0]  o_words_sent;
    logic              o_underflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushed_n = 0;
    int popped_n = 0;
    int ready_mode = 0;
    int words_model = 0;
    int stall_n = 0;
    bit drop_next = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;
    logic [35:0] fifo_q[$];
    logic [7:0]  rx_q[$];
    int          rx_cyc[$];
    int          rd_cyc[$];

    wbdbgbus_resp_serializer #(.CNT_WIDTH(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .o_rd_en     (o_rd_en),
        .i_rd_data   (i_rd_data),
        .i_rd_valid  (i_rd_valid),
        .i_empty     (i_empty),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_words_sent(o_words_sent),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    assign i_empty = (pushed_n == popped_n);

    // Response FIFO model: data appears the cycle after a pop
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_rd_en && fifo_q.size() > 0) begin
            popped_n <= popped_n + 1;
            if (drop_next) begin
                void'(fifo_q.pop_front());
                drop_next = 1'b0;
                i_rd_valid <= 1'b0;
            end else begin
                i_rd_data  <= fifo_q.pop_front();
                i_rd_valid <= 1'b1;
            end
        end else begin
            i_rd_valid <= 1'b0;
        end
    end

    // UART ready pattern: 0 = always ready, 1 = alternating, 2 = random
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            1:       i_tx_ready = ~i_tx_ready;
            2:       i_tx_ready = 1'($urandom_range(0, 1));
            default: i_tx_ready = 1'b1;
        endcase
    end

    // Byte monitor: records transfers, checks hold-during-stall and pop rules
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!o_tx_valid || o_tx_data !== stall_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                             o_tx_valid, o_tx_data, stall_data);
                end
            end
            if (o_rd_en) begin
                rd_cyc.push_back(cyc);
                checks++;
                if (o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_en_while_busy: busy=%0b, required 0", o_busy);
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                rx_q.push_back(o_tx_data);
                rx_cyc.push_back(cyc);
            end
            if (o_tx_valid && !i_tx_ready) stall_n++;
            stall_prev = o_tx_valid && !i_tx_ready;
            stall_data = o_tx_data;
        end
    end

    // Reference frame: byte k of a word, opcode first, checksum as the XOR of the rest
    function automatic logic [7:0] exp_byte(input logic [35:0] w, input int k);
        logic [39:0] x;
        logic [7:0]  c;
        x = {4'h0, w};
        c = 8'h00;
        if (k < 5) return x[8*(4-k) +: 8];
        for (int i = 0; i < 5; i++) c ^= x[8*(4-i) +: 8];
        return c;
    endfunction

    task automatic push_word(input logic [35:0] w);
        fifo_q.push_back(w);
        pushed_n++;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc.delete();
        rd_cyc.delete();
        stall_n = 0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        words_model = 0;
        clear_mon();
    endtask

    task automatic wait_done(input int nbytes, input string name);
        int t = 0;
        @(negedge i_clk);
        while ((rx_q.size() < nbytes || o_busy || !i_empty || i_rd_valid) && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d bytes, required %0d", name, rx_q.size(), nbytes);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks += 6;
        if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %0b, required 0", o_tx_valid); end
        if (o_tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %02h, required 00", o_tx_data); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, required 0", o_busy); end
        if (o_words_sent !== '0) begin errors++; $display("FAIL rst_words: got %0d, required 0", o_words_sent); end
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %0b, required 0", o_underflow); end
        if (o_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b, required 0", o_rd_en); end
    endtask

    task automatic test_single_frame();
        logic [7:0] ref_b[6];
        ref_b = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h21};
        clear_mon();
        ready_mode = 0;
        @(posedge i_clk); #2;
        push_word(36'h3_DEADBEEF);
        wait_done(FB, "single");
        words_model++;
        checks++;
        if (rx_q.size() != FB || rd_cyc.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d bytes %0d pops, required %0d bytes 1 pop",
                     rx_q.size(), rd_cyc.size(), FB);
        end else begin
            for (int k = 0; k < FB; k++) begin
                checks += 2;
                if (rx_q[k] !== ref_b[k]) begin
                    errors++;
                    $display("FAIL single_byte%0d: got %02h, required %02h", k, rx_q[k], ref_b[k]);
                end
                if (rx_cyc[k] != rd_cyc[0] + 2 + k) begin
                    errors++;
                    $display("FAIL single_cycle%0d: got N+%0d, required N+%0d",
                             k, rx_cyc[k] - rd_cyc[0], 2 + k);
                end
            end
        end
        checks += 2;
        if (o_words_sent !== CNT_W'(words_model)) begin
            errors++;
            $display("FAIL single_words: got %0d, required %0d", o_words_sent, words_model % 4);
        end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0b, required 0", o_busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] ref_b[6];
        ref_b = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h01};
        clear_mon();
        ready_mode = 1;
        @(posedge i_clk); #2;
        push_word(36'h1_01234567);
        wait_done(FB, "bp");
        ready_mode = 0;
        words_model++;
        checks += 2;
        if (rx_q.size() != FB) begin
            errors++;
            $display("FAIL bp_count: got %0d bytes, required %0d", rx_q.size(), FB);
        end else begin
            for (int k = 0; k < FB; k++) begin
                checks++;
                if (rx_q[k] !== ref_b[k]) begin
                    errors++;
                    $display("FAIL bp_byte%0d: got %02h, required %02h", k, rx_q[k], ref_b[k]);
                end
            end
        end
        if (stall_n == 0) begin errors++; $display("FAIL bp_stalls: got 0 stalled cycles, required >0"); end
        if (o_words_sent !== CNT_W'(words_model)) begin
            errors++;
            $display("FAIL bp_words: got %0d, required %0d", o_words_sent, words_model % 4);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] w[3];
        clear_mon();
        ready_mode = 0;
        @(posedge i_clk); #2;
        for (int i = 0; i < 3; i++) begin
            w[i] = {4'($urandom), 32'($urandom)};
            push_word(w[i]);
        end
        wait_done(3 * FB, "b2b");
        words_model += 3;
        checks += 2;
        if (rx_q.size() != 3 * FB || rd_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes %0d pops, required %0d bytes 3 pops",
                     rx_q.size(), rd_cyc.size(), 3 * FB);
        end else begin
            for (int i = 0; i < 3 * FB; i++) begin
                checks++;
                if (rx_q[i] !== exp_byte(w[i / FB], i % FB)) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %02h, required %02h", i, rx_q[i],
                             exp_byte(w[i / FB], i % FB));
                end
            end
            for (int f = 0; f < 2; f++) begin
                checks++;
                if (rx_cyc[(f + 1) * FB] - rx_cyc[f * FB] != FB + 2) begin
                    errors++;
                    $display("FAIL b2b_period%0d: got %0d cycles, required %0d", f,
                             rx_cyc[(f + 1) * FB] - rx_cyc[f * FB], FB + 2);
                end
            end
        end
        if (o_words_sent !== CNT_W'(words_model)) begin
            errors++;
            $display("FAIL b2b_words: got %0d, required %0d", o_words_sent, words_model % 4);
        end
    endtask

    task automatic test_underflow();
        logic [35:0] w;
        clear_mon();
        ready_mode = 0;
        @(posedge i_clk); #2;
        drop_next = 1'b1;
        push_word(36'h5_5A5A5A5A);
        wait_done(0, "uf");
        checks += 4;
        if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %0b, required 1", o_underflow); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL uf_idle: busy=%0b, required 0", o_busy); end
        if (rx_q.size() != 0) begin errors++; $display("FAIL uf_bytes: got %0d bytes, required 0", rx_q.size()); end
        if (o_words_sent !== CNT_W'(words_model)) begin
            errors++;
            $display("FAIL uf_words: got %0d, required %0d", o_words_sent, words_model % 4);
        end
        w = {4'($urandom), 32'($urandom)};
        @(posedge i_clk); #2;
        push_word(w);
        wait_done(FB, "uf_after");
        words_model++;
        checks += 2;
        if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %0b, required 1", o_underflow); end
        if (rx_q.size() != FB || rx_q[0] !== exp_byte(w, 0) || rx_q[FB-1] !== exp_byte(w, FB - 1)) begin
            errors++;
            $display("FAIL uf_next_frame: got %0d bytes, first %02h, required %0d bytes, first %02h",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, FB, exp_byte(w, 0));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [35:0] wa, wb;
        int t = 0;
        clear_mon();
        ready_mode = 0;
        wa = {4'($urandom), 32'($urandom)};
        wb = {4'($urandom), 32'($urandom)};
        @(posedge i_clk); #2;
        push_word(wa);
        push_word(wb);
        while (rx_q.size() < 3 && t < 100) begin @(negedge i_clk); t++; end
        @(posedge i_clk); #2;
        checks += 2;
        if (o_tx_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %0b, required 1", o_tx_valid); end
        i_rst_n = 1'b0;
        #1;
        if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %0b, required 0", o_tx_valid); end
        checks += 2;
        if (o_words_sent !== '0) begin errors++; $display("FAIL midrst_words: got %0d, required 0", o_words_sent); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b, required 0", o_busy); end
        repeat (2) @(negedge i_clk);
        words_model = 0;
        clear_mon();
        i_rst_n = 1'b1;
        wait_done(FB, "midrst");
        words_model++;
        checks += 2;
        if (rx_q.size() != FB) begin
            errors++;
            $display("FAIL midrst_count: got %0d bytes, required %0d", rx_q.size(), FB);
        end else begin
            for (int k = 0; k < FB; k++) begin
                checks++;
                if (rx_q[k] !== exp_byte(wb, k)) begin
                    errors++;
                    $display("FAIL midrst_byte%0d: got %02h, required %02h", k, rx_q[k], exp_byte(wb, k));
                end
            end
        end
        if (o_words_sent !== CNT_W'(words_model)) begin
            errors++;
            $display("FAIL midrst_words_after: got %0d, required %0d", o_words_sent, words_model % 4);
        end
    endtask

    task automatic test_random();
        logic [35:0] w[$];
        clear_mon();
        ready_mode = 2;
        for (int b = 0; b < 6; b++) begin
            int n = $urandom_range(1, 4);
            @(posedge i_clk); #2;
            for (int i = 0; i < n; i++) begin
                logic [35:0] x = {4'($urandom), 32'($urandom)};
                w.push_back(x);
                push_word(x);
            end
            repeat ($urandom_range(0, 20)) @(posedge i_clk);
        end
        wait_done(w.size() * FB, "rand");
        ready_mode = 0;
        words_model += w.size();
        checks += 2;
        if (rx_q.size() != w.size() * FB) begin
            errors++;
            $display("FAIL rand_count: got %0d bytes, required %0d", rx_q.size(), w.size() * FB);
        end else begin
            for (int i = 0; i < rx_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_byte(w[i / FB], i % FB)) begin
                    errors++;
                    $display("FAIL rand_byte%0d: got %02h, required %02h", i, rx_q[i],
                             exp_byte(w[i / FB], i % FB));
                end
            end
        end
        if (o_words_sent !== CNT_W'(words_model)) begin
            errors++;
            $display("FAIL rand_words: got %0d, required %0d", o_words_sent, words_model % 4);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++;
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL wrap_uf_cleared: got %0b, required 0", o_underflow); end
        ready_mode = 0;
        @(posedge i_clk); #2;
        for (int i = 0; i < 5; i++) push_word({4'($urandom), 32'($urandom)});
        wait_done(5 * FB, "wrap");
        checks += 2;
        if (rx_q.size() != 5 * FB) begin
            errors++;
            $display("FAIL wrap_count: got %0d bytes, required %0d", rx_q.size(), 5 * FB);
        end
        if (o_words_sent !== CNT_W'(1)) begin
            errors++;
            $display("FAIL wrap_words: got %0d, required 1", o_words_sent);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_underflow();
        test_reset_mid_frame();
        test_random();
        test_wrap();
        repeat (2) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wbdbgbus_resp_serializer.md
# wbdbgbus_resp_serializer

Drains 36-bit debug-bus response words from the response FIFO and serializes each one, MSB first, into a byte stream for the UART transmitter. It sits between the response FIFO's read port and the UART TX byte handshake, and is the consumer end of that FIFO. Each word is one 4-bit opcode plus 32 data bits, and becomes a fixed-length byte frame.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the sent-word counter.

Ports:
- `i_clk`, in, 1: clock; all logic is on the rising edge.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `o_rd_en`, out, 1: FIFO pop request.
- `i_rd_data`, in, 36: FIFO read data; valid the cycle after a pop.
- `i_rd_valid`, in, 1: FIFO read-data valid, one cycle after `o_rd_en`.
- `i_empty`, in, 1: FIFO empty flag.
- `o_tx_data`, out, 8: byte to the UART TX.
- `o_tx_valid`, out, 1: byte valid.
- `i_tx_ready`, in, 1: UART TX accepts the byte.
- `o_busy`, out, 1: high in any state other than S_IDLE.
- `o_words_sent`, out, CNT_WIDTH: count of completed frames; wraps modulo 2^CNT_WIDTH.
- `o_underflow`, out, 1: sticky; set when a pop returns no valid data.

## Operation
States:
- **S_IDLE**
  - `o_rd_en = !i_empty` (combinational).
  - If `o_rd_en` is high, go to S_WAIT.
- **S_WAIT**
  - If `i_rd_valid` is high:
    - latch `i_rd_data` into the frame register;
    - set byte index to 0;
    - go to S_SEND.
  - Otherwise:
    - set `o_underflow`;
    - go to S_IDLE.
- **S_SEND**
  - `o_tx_valid = 1`.
  - `o_tx_data` is the frame byte selected by the index.
  - On `i_tx_ready`, increment the index.
  - On acceptance of the last byte:
    - increment `o_words_sent`;
    - go to S_IDLE.

Frame layout:
- byte0 = `{4'h0, word[35:32]}`
- byte1 = `word[31:24]`
- byte2 = `word[23:16]`
- byte3 = `word[15:8]`
- byte4 = `word[7:0]`

Rules:
- A byte is transferred only in a cycle where `o_tx_valid && i_tx_ready`.
- Once `o_tx_valid` is asserted, `o_tx_data` holds stable until the byte is accepted.
- `o_rd_en` is never asserted outside S_IDLE; at most one word is in flight.
- `i_empty` changes during S_SEND are ignored.
- The byte index is 3 bits, and its last value is `FRAME_BYTES-1`.
- `o_underflow` clears only on reset.

## Timing
- Reset values:
  - `o_tx_valid=0`, `o_tx_data=8'h00`
  - `o_busy=0`, `o_words_sent=0`, `o_underflow=0`
  - state S_IDLE; frame register 0
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately: `o_tx_valid` drops without waiting for a clock, and the partial word is lost.
- Latency: with `i_empty` low in cycle N, `o_rd_en` is high in N, data is latched in N+1, and byte0 is valid in N+2.
- Back-to-back: with `i_tx_ready` held high, a 5-byte frame occupies N+2..N+6. The earliest next pop is N+7, giving 7 cycles per word (8 with checksum).
- `i_tx_ready` may toggle arbitrarily; each low cycle stalls the frame one cycle with no byte skipped or repeated.

## Configuration
- `WBDBGBUS_CHECKSUM_EN` defined:
  - `FRAME_BYTES=6`;
  - byte5 = XOR of bytes 0–4;
  - `o_words_sent` increments after byte5.
- Undefined:
  - `FRAME_BYTES=5`;
  - no checksum logic is present.

## Structure
- `wbdbgbus_pkg` contains:
  - the state enum `resp_state_t` (S_IDLE, S_WAIT, S_SEND);
  - `RESP_WORD_WIDTH=36` and `RESP_OP_WIDTH=4`;
  - the `FRAME_BYTES` localparam derived from the macro.
- No sub-module. Byte selection and the checksum are inline combinational logic; the response FIFO is instantiated by the parent.

## Test plan
- **Single frame.** Push 36'h3_DEADBEEF with `i_tx_ready=1` → bytes 03, DE, AD, BE, EF on consecutive cycles starting 2 cycles after `o_rd_en`; then `o_words_sent=1` and `o_busy=0`.
- **Checksum.** With `WBDBGBUS_CHECKSUM_EN` and the same word → sixth byte is 21.
- **Backpressure.** `i_tx_ready` alternates 0/1 for word 36'h1_01234567 → exactly 01, 01, 23, 45, 67 are transferred; `o_tx_data` is stable during every stall.
- **Back-to-back.** Three words queued, `i_tx_ready=1` → 15 bytes with a 2-cycle gap between frames; `o_words_sent=3`; `o_rd_en` is never high while busy.
- **Reset mid-frame.** Drop `i_rst_n` after byte2 → `o_tx_valid=0` with no clock edge; after release, the next queued word starts from byte0.
- **Underflow and wrap.** Drive `i_rd_valid=0` after a pop → `o_underflow=1`, state returns to S_IDLE. With `CNT_WIDTH=2`, 5 frames → `o_words_sent=1`.
